// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int DEFAULT_DEPTH = 1024;
    localparam int IDX_W         = $clog2(DEFAULT_DEPTH);

    // The latency counter is 8 bits wide.
    // The legal LATENCY range follows from that width.
    localparam int CNT_W   = 8;
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = (1 << CNT_W) - 1;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W, write-enable, registered read.
// Latency: write lands at the enabled edge; read data appears one edge after the enabled read.
// Backpressure: none; one access per enabled cycle. rdata holds between reads.
// Ports: clk; en (access strobe); we (1 = write); addr (word index); wdata; rdata (registered).
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // rdata only moves on reads, so it holds the last read word through writes.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port: one word read/write per request.
// Latency: ack_o pulses in the cycle after edge T0+LATENCY, where T0 is the accepting edge.
// Backpressure: req_i is held until ack_o; no new request is taken in WAIT or ACK.
// Ports: clk_i, rst_i (async, active-high); req_i, write_i, addr_i (byte address), wdata_i;
//        ack_o (one-cycle pulse), rdata_o (valid with ack_o on reads), busy_o (WAIT or ACK).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              write_i,
    input  logic [31:0]       addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              ack_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    generate
        if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
            $error("dmem_responder: LATENCY out of range");
        end
    endgenerate

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              req_we_q;
    logic [AW-1:0]     req_idx_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic              rd_vld_q;
    logic              access;
    logic [DATA_W-1:0] ram_rdata;

    // Address bits above the index alias; bits [1:0] are ignored.
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:2+AW], addr_i[1:0]};

    // LATENCY=1 still passes through WAIT with the counter at 0, so the
    // access/ack timing is the same formula for every latency.
    always_comb begin
        state_d = state_q;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ACK;
                    access  = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_we_q    <= 1'b0;
            req_idx_q   <= '0;
            req_wdata_q <= '0;
            rd_vld_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_i) begin
                req_we_q    <= write_i;
                req_idx_q   <= addr_i[2 +: AW];
                req_wdata_q <= wdata_i;
                cnt_q       <= CNT_LOAD;
            end else if (state_q == WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            // Until the first read completes, the RAM output register holds
            // nothing meaningful, so rdata_o is forced to 0.
            if (access && !req_we_q) begin
                rd_vld_q <= 1'b1;
            end
        end
    end

    // Reset forces state_q to IDLE asynchronously, so access is low and a
    // pending write can never reach the array.
    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk   (clk_i),
        .en    (access),
        .we    (req_we_q),
        .addr  (req_idx_q),
        .wdata (req_wdata_q),
        .rdata (ram_rdata)
    );

    assign ack_o   = (state_q == ACK);
    assign busy_o  = (state_q != IDLE);
    assign rdata_o = rd_vld_q ? ram_rdata : '0;

endmodule
